// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// a constant helper that sizes the bit counter.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing a - b - bin LSB first with one cell.
// Optional macro SERIAL_SUB_SAT_EN clamps d to zero when the result underflows.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output state_t           state
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  // Handshake: start is sampled only in IDLE; an accepted start raises busy on
  // the next cycle, and done pulses for one cycle when d/bout are fresh.
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] r;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             diff;
  logic             bo;
  logic             last;
  logic [WIDTH-1:0] res;

  full_subtractor u_cell (
    .x (sa[0]),
    .y (sb[0]),
    .bi(br),
    .d (diff),
    .bo(bo)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign res  = {diff, r[WIDTH-1:1]};
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last)  state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      r    <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        ST_SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= bo;
          r   <= res;
          cnt <= cnt + CW'(1);
          if (last) begin
`ifdef SERIAL_SUB_SAT_EN
            d <= bo ? '0 : res;
`else
            d <= res;
`endif
            bout <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) with a result scoreboard.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  state_t       state;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic binv);
    logic [W:0] v;
    v = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
`ifdef SERIAL_SUB_SAT_EN
    if (v[W]) v[W-1:0] = '0;
`endif
    return v;
  endfunction

  // Drives one operation from IDLE; returns latency, result, done pulses, busy cycles
  // and whether d/bout held their prior value until completion.
  task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                          input bit hold, output int lat, output logic [W:0] got,
                          output int pulses, output int busy_cnt, output bit stable);
    logic [W:0] prev;
    prev = {bout, d};
    a = av; b = bv; bin = binv; start = 1'b1;
    exp_q.push_back(model(av, bv, binv));
    tick;
    if (!hold) start = 1'b0;
    a = ~av; b = ~bv; bin = ~binv;
    lat = 0; pulses = 0; busy_cnt = 0; stable = 1'b1;
    if (busy === 1'b1) busy_cnt++;
    while (done !== 1'b1 && lat < 20) begin
      tick;
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b1 && {bout, d} !== prev) stable = 1'b0;
    end
    got = {bout, d};
    if (done === 1'b1) pulses = 1;
    tick;
    if (done === 1'b1) pulses++;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    checks++;
    if ({busy, done, d, bout} !== '0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b d=%h bout=%b state=%0d, required all zero/IDLE",
               busy, done, d, bout, state);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b state=%0d, required 0/IDLE", busy, state);
    end
  endtask

  task automatic test_basic;
    int lat, pulses, bc;
    bit stable;
    logic [W:0] got, e;
    drive_op(4'd9, 4'd3, 1'b0, 1'b0, lat, got, pulses, bc, stable);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || got !== 5'b0_0110) begin
      errors++;
      $display("FAIL basic_result: got %b, required %b", got, e);
    end
    checks++;
    if (lat !== W) begin
      errors++;
      $display("FAIL basic_latency: got %0d, required %0d", lat, W);
    end
    checks++;
    if (bc !== W) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, required %0d", bc, W);
    end
    checks++;
    if (pulses !== 1 || !stable) begin
      errors++;
      $display("FAIL basic_pulse_stable: pulses %0d stable %0d, required 1 1", pulses, stable);
    end
  endtask

  task automatic test_vectors;
    logic [W:0] want [3];
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic binv [3];
    int lat, pulses, bc;
    bit stable;
    logic [W:0] got, e;
    av[0] = 4'd3; bv[0] = 4'd9; binv[0] = 1'b0;
    av[1] = 4'd0; bv[1] = 4'd0; binv[1] = 1'b1;
    av[2] = 4'd7; bv[2] = 4'd7; binv[2] = 1'b0;
`ifdef SERIAL_SUB_SAT_EN
    want[0] = 5'b1_0000; want[1] = 5'b1_0000;
`else
    want[0] = 5'b1_1010; want[1] = 5'b1_1111;
`endif
    want[2] = 5'b0_0000;
    for (int i = 0; i < 3; i++) begin
      drive_op(av[i], bv[i], binv[i], 1'b0, lat, got, pulses, bc, stable);
      e = exp_q.pop_front();
      checks++;
      if (got !== want[i] || got !== e) begin
        errors++;
        $display("FAIL vector_%0d: got {bout,d}=%b, required %b", i, got, want[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat, pulses, bc;
    bit stable;
    logic [W:0] got, e;
    drive_op(4'd9, 4'd3, 1'b0, 1'b1, lat, got, pulses, bc, stable);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || pulses !== 1 || lat !== W) begin
      errors++;
      $display("FAIL ignore_start: got %b pulses %0d lat %0d, required %b 1 %0d",
               got, pulses, lat, e, W);
    end
    checks++;
    if (busy !== 1'b0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL start_in_done: busy=%b state=%0d, required 0/IDLE", busy, state);
    end
  endtask

  task automatic test_reset_mid;
    int lat, pulses, bc;
    bit stable;
    logic [W:0] got, e;
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({busy, done, d, bout} !== '0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b d=%h bout=%b, required all zero",
               busy, done, d, bout);
    end
    drive_op(4'd5, 4'd2, 1'b0, 1'b0, lat, got, pulses, bc, stable);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || got !== 5'b0_0011) begin
      errors++;
      $display("FAIL after_reset_op: got %b, required %b", got, e);
    end
  endtask

  task automatic test_exhaustive;
    int lat, pulses, bc;
    bit stable;
    logic [W:0] got, e;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          drive_op(W'(ai), W'(bi), ci[0], $urandom_range(0, 3) == 0,
                   lat, got, pulses, bc, stable);
          e = exp_q.pop_front();
          checks++;
          if (got !== e || lat !== W || pulses !== 1 || !stable) begin
            errors++;
            $display("FAIL exhaustive a=%0d b=%0d bin=%0d: got %b lat %0d pulses %0d stable %0d, required %b %0d 1 1",
                     ai, bi, ci, got, lat, pulses, stable, e, W);
          end
        end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_ignore_start;
    test_reset_mid;
    test_exhaustive;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
